// File: rtl/prog_updn_counter.sv
// prog_updn_counter: programmable-step up/down counter with wrap, saturate and one-shot modes
module prog_updn_counter #(
    parameter int WIDTH  = 8,
    parameter int MAXVAL = 2**WIDTH-1,
    parameter int MODE   = 0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Clear,
    input  logic             Enable,
    input  logic             Load,
    input  logic             UpDn,
    input  logic [WIDTH-1:0] Data,
    input  logic [WIDTH-1:0] Step,
    output logic [WIDTH-1:0] Q,
    output logic             Bound,
    output logic             Done,
    output logic             Zero
);
    typedef enum logic {RUN, DONE} state_t;
    localparam logic [WIDTH-1:0] MAXQ = WIDTH'(MAXVAL);
    localparam logic [WIDTH:0]   MAXE = (WIDTH+1)'(MAXVAL);
    localparam logic [WIDTH:0]   LIM  = (WIDTH+1)'(MAXVAL + 1);
    state_t state, state_nxt;
    logic [WIDTH-1:0] q_nxt, cnt, ld;
    logic [WIDTH:0] sum;
    logic bound_nxt, over, under, clip, hit;
    assign sum   = {1'b0, Q} + {1'b0, Step};
    assign over  = sum > MAXE;
    assign under = Step > Q;
    assign clip  = UpDn ? over : under;
    assign ld    = Data > MAXQ ? MAXQ : Data;
    assign cnt   = UpDn ? (over ? (MODE == 0 ? WIDTH'(sum - LIM) : MAXQ) : sum[WIDTH-1:0])
                        : (under ? (MODE == 0 ? WIDTH'({1'b0, Q} + LIM - {1'b0, Step}) : '0) : Q - Step);
    // one-shot finishes on any nonzero step that lands on or clips to the end value
    assign hit   = MODE == 2 && Step != '0 && cnt == (UpDn ? MAXQ : '0);
    always_comb begin
        q_nxt     = Q;
        bound_nxt = 1'b0;
        state_nxt = state;
        if (Clear) begin
            q_nxt     = '0;
            state_nxt = RUN;
        end else if (Load) begin
            q_nxt     = ld;
            state_nxt = RUN;
        end else if (Enable && state == RUN) begin
            q_nxt     = cnt;
            bound_nxt = MODE == 2 ? hit : clip;
            state_nxt = hit ? DONE : RUN;
        end
    end
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Q     <= '0;
            Bound <= 1'b0;
            state <= RUN;
        end else begin
            Q     <= q_nxt;
            Bound <= bound_nxt;
            state <= state_nxt;
        end
    end
    assign Done = state == DONE;
    assign Zero = Q == '0;
endmodule

// File: doc/prog_updn_counter.md
PROG_UPDN_COUNTER -- requirements
Module: prog_updn_counter

Interface
REQ-001 Parameter WIDTH, default 8: width of Data, Step and Q.
REQ-002 Parameter MAXVAL, default 2**WIDTH-1: upper count bound; legal range is 1 to 2**WIDTH-1.
REQ-003 Parameter MODE, default 0: 0 = wrap, 1 = saturate, 2 = one-shot.
REQ-004 Clock  input  1  rising-edge clock.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 Clear  input  1  synchronous clear to 0.
REQ-007 Enable  input  1  count enable.
REQ-008 Load  input  1  synchronous parallel load of Data.
REQ-009 UpDn  input  1  1 = count up, 0 = count down.
REQ-010 Data  input  WIDTH  load value.
REQ-011 Step  input  WIDTH  increment or decrement amount per enabled cycle.
REQ-012 Q  output  WIDTH  registered count.
REQ-013 Bound  output  1  registered one-cycle pulse marking a wrap or clip event.
REQ-014 Done  output  1  registered one-shot completion flag; always 0 when MODE != 2.
REQ-015 Zero  output  1  combinational (Q == 0).

Function
REQ-016 Priority per rising edge SHALL be Reset > Clear > Load > enabled count > hold.
REQ-017 Clear SHALL set Q=0 and Done=0 and SHALL leave Bound=0 that cycle.
REQ-018 Load SHALL act regardless of Enable.
  - Q = min(Data, MAXVAL); Done=0; Bound=0.
REQ-019 Enable=1 with Load=0 and Clear=0 SHALL update Q per REQ-020..REQ-023; otherwise Q holds and Bound=0.
REQ-020 Up, Q+Step <= MAXVAL: Q = Q+Step.
  - Sum computed WIDTH+1 bits wide; no silent truncation.
REQ-021 Up, Q+Step > MAXVAL, Bound=1 next cycle:
  - wrap: Q = Q+Step-(MAXVAL+1)
  - saturate and one-shot: Q = MAXVAL
REQ-022 Down, Step <= Q: Q = Q-Step.
REQ-023 Down, Step > Q, Bound=1 next cycle:
  - wrap: Q = Q+(MAXVAL+1)-Step
  - saturate and one-shot: Q = 0
REQ-024 Step=0 SHALL hold Q with Bound=0.
  - Step > MAXVAL is illegal; behaviour is undefined and the bench SHALL not drive it.
REQ-025 Saturate mode, Q already at the bound in the count direction: Q holds and Bound SHALL pulse every enabled cycle.
REQ-026 One-shot mode SHALL run a 2-state machine, RUN and DONE.
  - RUN -> DONE on the enabled cycle where Q reaches MAXVAL (up) or 0 (down), including an exact landing.
  - DONE sets Done=1 and ignores Enable; Q freezes.
  - DONE -> RUN only on Load or Clear.
REQ-027 In one-shot mode, Bound SHALL pulse on the RUN->DONE transition cycle only.
REQ-028 Bound SHALL be a single-cycle pulse. It SHALL deassert the cycle after the event unless a new event occurs.
REQ-029 Direction changes (UpDn toggling) SHALL take effect on the same edge, with no pipeline delay.

Reset
REQ-030 Reset=1 SHALL asynchronously force Q=0, Bound=0, Done=0 and state RUN, independent of Clock.
REQ-031 Reset deassertion SHALL be followed by normal operation from the first subsequent rising edge.
REQ-032 Reset mid-count or in DONE SHALL abort without completing the in-flight update.

Verification (WIDTH=8, MAXVAL=9)
REQ-033 MODE=0, Q=8, Step=3, UpDn=1, Enable=1, one edge -> Q=1, Bound=1 for 1 cycle.
REQ-034 MODE=0, Q=1, Step=3, UpDn=0, one edge -> Q=8, Bound=1; next edge with Step=0 -> Q=8, Bound=0.
REQ-035 MODE=1, Q=7, Step=2, up, three edges -> Q=9,9,9.
  - Bound=0,1,1.
REQ-036 MODE=2, Load Data=5 then Step=2 down -> Q=3,1,0 with Done=1 after the third edge.
  - Further Enable -> Q=0 held, Bound=0.
  - Load Data=4 -> Q=4, Done=0.
REQ-037 Load Data=200 with Enable=0 -> Q=9.
  - Same edge Clear=1 and Load=1 -> Q=0.
REQ-038 Reset asserted mid-cycle between edges while Q=6 -> Q=0, Bound=0, Done=0 immediately; first edge after release counts from 0.
